// File: rtl/clock_generator.sv
// clock_generator: programmable divider producing a 50 %-duty stage clock
// from the reference clock clk, with single-cycle rise/fall strobes.
// Optional feature macro: CLKGEN_CYCLE_COUNT_EN adds the 32-bit cycle_count
// output counting rising edges of the generated clock.
module clock_generator #(
    parameter int DIV_WIDTH    = 8,
    parameter int DEFAULT_HALF = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic [DIV_WIDTH-1:0] div,
    input  logic                 div_load,
    output logic                 clock,
    output logic                 rise_stb,
    output logic                 fall_stb
`ifdef CLKGEN_CYCLE_COUNT_EN
    ,
    output logic [31:0]          cycle_count
`endif
);

    localparam logic [DIV_WIDTH-1:0] HP_RESET = DIV_WIDTH'(DEFAULT_HALF);
    localparam logic [DIV_WIDTH-1:0] HP_ONE   = DIV_WIDTH'(1);

    // A requested half-period of zero is promoted to one clk cycle.
    function automatic logic [DIV_WIDTH-1:0] norm_half(input logic [DIV_WIDTH-1:0] d);
        if (d == '0) begin
            return HP_ONE;
        end else begin
            return d;
        end
    endfunction

    logic [DIV_WIDTH-1:0] hp_r,   hp_s;
    logic [DIV_WIDTH-1:0] pend_r, pend_s;
    logic                 pv_r,   pv_s;
    logic [DIV_WIDTH-1:0] cnt_r,  cnt_s;
    logic                 clock_r, clock_s;
    logic                 rise_r,  rise_s;
    logic                 fall_r,  fall_s;
    logic                 run_s;
    logic                 terminal_s;
`ifdef CLKGEN_CYCLE_COUNT_EN
    logic [31:0]          cycle_count_r, cycle_count_s;
`endif

    // Next-state: phase counting, toggling, ratio hand-over and stop/park.
    always_comb begin
        hp_s       = hp_r;
        pend_s     = pend_r;
        pv_s       = pv_r;
        cnt_s      = cnt_r;
        clock_s    = clock_r;
        rise_s     = 1'b0;
        fall_s     = 1'b0;
        // A high phase always runs to completion, even after en drops.
        run_s      = en | clock_r;
        terminal_s = (cnt_r == (hp_r - HP_ONE));

        if (run_s) begin
            if (terminal_s) begin
                clock_s = ~clock_r;
                cnt_s   = '0;
                rise_s  = ~clock_r;
                fall_s  = clock_r;
                // New ratio only takes over at a falling toggle so both
                // halves of every period use the same half-period.
                if (clock_r && pv_r) begin
                    hp_s = pend_r;
                    pv_s = 1'b0;
                end else begin
                    hp_s = hp_r;
                    pv_s = pv_r;
                end
            end else begin
                cnt_s = cnt_r + HP_ONE;
            end
        end else begin
            // Parked low: counter held, pending ratio taken immediately.
            cnt_s = '0;
            if (pv_r) begin
                hp_s = pend_r;
                pv_s = 1'b0;
            end else begin
                hp_s = hp_r;
            end
        end

        // A load in the hand-over cycle is kept pending, not bypassed.
        if (div_load) begin
            pend_s = norm_half(div);
            pv_s   = 1'b1;
        end else begin
            pend_s = pend_r;
        end

`ifdef CLKGEN_CYCLE_COUNT_EN
        if (rise_s) begin
            cycle_count_s = cycle_count_r + 32'd1;
        end else begin
            cycle_count_s = cycle_count_r;
        end
`endif
    end

    // State and output registers; reset aborts any phase and drops pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hp_r    <= HP_RESET;
            pend_r  <= HP_RESET;
            pv_r    <= 1'b0;
            cnt_r   <= '0;
            clock_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            hp_r    <= hp_s;
            pend_r  <= pend_s;
            pv_r    <= pv_s;
            cnt_r   <= cnt_s;
            clock_r <= clock_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
        end
    end

`ifdef CLKGEN_CYCLE_COUNT_EN
    // Rising-edge counter; free-running wrap, unaffected by en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_count_r <= 32'd0;
        end else begin
            cycle_count_r <= cycle_count_s;
        end
    end

    assign cycle_count = cycle_count_r;
`endif

    assign clock    = clock_r;
    assign rise_stb = rise_r;
    assign fall_stb = fall_r;

endmodule

// File: tb/tb_clock_generator.sv
// Testbench for clock_generator: cycle-level scoreboard fed by a
// remaining-cycles reference model, plus fixed-cycle spot checks.
module tb_clock_generator;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic [7:0] div = 8'd0;
    logic       div_load = 1'b0;
    logic       clock;
    logic       rise_stb;
    logic       fall_stb;
`ifdef CLKGEN_CYCLE_COUNT_EN
    logic [31:0] cycle_count;
`endif

    always #5 clk = ~clk;

    clock_generator #(.DIV_WIDTH(8), .DEFAULT_HALF(5)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .div      (div),
        .div_load (div_load),
        .clock    (clock),
        .rise_stb (rise_stb),
        .fall_stb (fall_stb)
`ifdef CLKGEN_CYCLE_COUNT_EN
        ,
        .cycle_count (cycle_count)
`endif
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    logic [2:0] exp_q[$];

    // Reference model: cycles left in the current phase, counting down.
    bit m_clock;
    int m_left;
    int m_hp;
    int m_pend;
    bit m_pv;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_clock = 1'b0;
        m_hp    = 5;
        m_left  = 5;
        m_pend  = 5;
        m_pv    = 1'b0;
        cyc     = 0;
        exp_q.delete();
    endtask

    // Advance the model with the inputs about to be sampled, push the
    // expectation, then let the DUT clock and compare against the queue.
    task automatic tick();
        bit r;
        bit f;
        r = 1'b0;
        f = 1'b0;
        if (en || m_clock) begin
            if (m_left == 1) begin
                if (m_clock) begin
                    f = 1'b1;
                    if (m_pv) begin
                        m_hp = m_pend;
                        m_pv = 1'b0;
                    end
                end else begin
                    r = 1'b1;
                end
                m_clock = !m_clock;
                m_left  = m_hp;
            end else begin
                m_left--;
            end
        end else begin
            if (m_pv) begin
                m_hp = m_pend;
                m_pv = 1'b0;
            end
            m_left = m_hp;
        end
        if (div_load) begin
            m_pend = (div == 8'd0) ? 1 : int'(div);
            m_pv   = 1'b1;
        end
        exp_q.push_back({m_clock, r, f});
        @(posedge clk);
        #1;
        cyc++;
        check_val("outputs", 32'({clock, rise_stb, fall_stb}), 32'(exp_q.pop_front()));
    endtask

    task automatic load_tick(input logic [7:0] d);
        div      = d;
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
    endtask

    task automatic wait_edge(input bit want_rise, input int bound, input string tag);
        bit found;
        found = 1'b0;
        for (int i = 0; i < bound && !found; i++) begin
            tick();
            if (want_rise ? rise_stb : fall_stb) found = 1'b1;
        end
        if (!found) check_val(tag, 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rcyc;
        int fcyc;
        int nfall;
        int start;

        // Reset state
        model_reset();
        en = 1'b1;
        #12;
        check_val("reset_out", 32'({clock, rise_stb, fall_stb}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Default ratio: rise at 5,15,25, fall at 10,20
        for (int i = 0; i < 25; i++) begin
            tick();
            check_val("t1_clock", 32'(clock), 32'((cyc % 10) >= 5));
            check_val("t1_rise", 32'(rise_stb), 32'((cyc % 10) == 5));
            check_val("t1_fall", 32'(fall_stb), 32'((cyc % 10) == 0));
        end

        // div=3 loaded in a high phase: high stays 5, then 3/3
        load_tick(8'd3);
        wait_edge(1'b0, 20, "t2_fall_timeout");
        check_val("t2_fall_cyc", 32'(cyc), 32'd30);
        wait_edge(1'b1, 20, "t2_rise_timeout");
        check_val("t2_rise_cyc", 32'(cyc), 32'd33);
        wait_edge(1'b0, 20, "t2_fall2_timeout");
        check_val("t2_fall2_cyc", 32'(cyc), 32'd36);

        // div=0 treated as 1: toggles every cycle after next fall
        load_tick(8'd0);
        wait_edge(1'b0, 20, "t3_fall_timeout");
        check_val("t3_fall_cyc", 32'(cyc), 32'd42);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_val("t3_clock", 32'(clock), 32'(i % 2 == 0));
            check_val("t3_strobes", 32'({rise_stb, fall_stb}), (i % 2 == 0) ? 32'd2 : 32'd1);
        end

        // Stop two cycles into a high phase of hp=5
        load_tick(8'd5);
        wait_edge(1'b0, 20, "t4_fall_timeout");
        wait_edge(1'b1, 20, "t4_rise_timeout");
        rcyc = cyc;
        tick();
        en    = 1'b0;
        nfall = 0;
        fcyc  = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (fall_stb) begin
                nfall++;
                fcyc = cyc;
            end
        end
        check_val("t4_fall_count", 32'(nfall), 32'd1);
        check_val("t4_fall_cyc", 32'(fcyc), 32'(rcyc + 5));
        check_val("t4_parked", 32'(clock), 32'd0);
        // Load while parked takes effect at once; restart rises hp later
        load_tick(8'd3);
        tick();
        start = cyc;
        en    = 1'b1;
        wait_edge(1'b1, 20, "t4_restart_timeout");
        check_val("t4_restart_cyc", 32'(cyc), 32'(start + 3));

        // Async reset mid high phase with a pending ratio
        wait_edge(1'b1, 20, "t5_rise_timeout");
        load_tick(8'd7);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("t5_async_clock", 32'(clock), 32'd0);
        check_val("t5_async_stb", 32'({rise_stb, fall_stb}), 32'd0);
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        wait_edge(1'b1, 20, "t5_rise_timeout2");
        check_val("t5_rise_cyc", 32'(cyc), 32'd5);
        wait_edge(1'b0, 20, "t5_fall_timeout");
        check_val("t5_fall_cyc", 32'(cyc), 32'd10);
        wait_edge(1'b1, 20, "t5_rise2_timeout");
        check_val("t5_rise2_cyc", 32'(cyc), 32'd15);

`ifdef CLKGEN_CYCLE_COUNT_EN
        // Rising-edge counter wrap
        force dut.cycle_count_r = 32'hFFFF_FFFE;
        #2;
        release dut.cycle_count_r;
        wait_edge(1'b1, 20, "t6_rise_timeout");
        check_val("t6_count_max", cycle_count, 32'hFFFF_FFFF);
        wait_edge(1'b1, 20, "t6_rise2_timeout");
        check_val("t6_count_wrap", cycle_count, 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_generator.md
# clock_generator

Programmable clock divider that derives the processor's stage clock `clock` from the reference clock `clk`. It produces a 50 %-duty square wave with a run-time selectable half-period, plus single-cycle edge strobes aligned with each transition. It sits at the top of the pipeline and feeds the instruction memory, register file and pipeline registers.

## Interface
- `DIV_WIDTH`, 8: width of the half-period request.
- `DEFAULT_HALF`, 5: half-period in `clk` cycles after reset (period 10).
- `clk`  input  1  reference clock. One clock, all logic on its rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `en`  input  1  run enable.
- `div`  input  DIV_WIDTH  requested half-period in `clk` cycles; 0 is treated as 1.
- `div_load`  input  1  strobe: capture `div` as the pending half-period.
- `clock`  output  1  generated clock (registered).
- `rise_stb`  output  1  high for the single `clk` cycle in which `clock` is 1 after being 0.
- `fall_stb`  output  1  high for the single `clk` cycle in which `clock` is 0 after being 1.
- `cycle_count`  output  32  number of `clock` rising edges (only with `CLKGEN_CYCLE_COUNT_EN`).

## Operation
- State: active half-period `hp`, pending half-period `pend` with valid flag `pv`, phase counter `cnt` (DIV_WIDTH bits), output level.
- Running (`en`=1): `cnt` increments every `clk`. When `cnt == hp-1`: toggle `clock`, set `cnt` to 0, pulse the matching strobe.
- Ratio change: on `div_load`, `pend <= (div==0 ? 1 : div)`, `pv <= 1`. Multiple loads before application: last wins. `pend` is applied (`hp <= pend`, `pv <= 0`) only in the cycle `clock` toggles 1->0. The following low phase uses the new value. A load in that same cycle is not bypassed and is applied at the next falling toggle.
- Stop (`en`=0): if `clock` is high, the current high phase completes normally, including the falling toggle and `fall_stb`. `clock` then parks low with `cnt` held at 0. If `clock` is low, it stays low and `cnt` is held at 0.
- While parked low with `en`=0, a pending value is applied immediately in the next cycle.
- Restart: after `en` rises, the first rising toggle occurs `hp` cycles later.
- Reset: `clock`=0, `rise_stb`=`fall_stb`=0, `cnt`=0, `hp`=DEFAULT_HALF, `pv`=0, `cycle_count`=0. Reset mid-phase aborts the phase immediately. A pending value is discarded.

## Timing
- All outputs are registered and change only on `clk` rising edges. `rise_stb`/`fall_stb` are asserted in the same cycle as the new `clock` level.
- Steady-state period is 2·`hp` `clk` cycles with exact 50 % duty. `hp`=1 gives `clock` toggling every `clk` cycle.
- With `en`=1 from release of reset, the first `rise_stb` occurs in cycle DEFAULT_HALF after reset deasserts. Counting starts at cycle 1.
- `div` and `div_load` are sampled synchronously. Latency to effect is up to one full `clock` period.

## Configuration
- `CLKGEN_CYCLE_COUNT_EN` defined: `cycle_count` exists. It increments by 1 in each `rise_stb` cycle and wraps from 2^32-1 to 0. It is not cleared by `en`.
- Not defined: the `cycle_count` port and its counter are omitted. All other behaviour is identical.

## Test plan
- Reset, `en`=1, default: `clock` low for 5 cycles, then high for 5. `rise_stb` pulses at cycles 5, 15, 25 and `fall_stb` at cycles 10, 20.
- `div`=3 with `div_load` during a high phase: the current high phase stays 5, then low 3 / high 3 (period 6).
- `div`=0 loaded: after the next fall, `clock` toggles every `clk` cycle and strobes alternate every cycle.
- Deassert `en` 2 cycles into a high phase: `clock` stays high 3 more cycles, `fall_stb` pulses once, then parks low. Reassert `en`: rise after `hp` cycles.
- Assert `rst_n`=0 asynchronously mid high phase: `clock` drops to 0 immediately without waiting for `clk`. The pending ratio is discarded and `hp` returns to 5.
- With `CLKGEN_CYCLE_COUNT_EN` defined and the counter preset near 2^32-1 by force: two rises give 2^32-1 then 0.
